// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO with registered or show-ahead read, threshold flags and occupancy count.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_EN is defined.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned DATA_DEPTH    = 10,
  parameter int unsigned AFULL_THRESH  = 2**DATA_DEPTH - 4,
  parameter int unsigned AEMPTY_THRESH = 4,
  parameter int unsigned SHOW_AHEAD    = 0
) (
  input  logic                  fifo_clk,
  input  logic                  fifo_rst_n,
  input  logic                  clr,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [DATA_DEPTH:0]   use_num,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned AW    = DATA_DEPTH;
  localparam int unsigned CNT_W = DATA_DEPTH + 1;
  localparam int unsigned DEPTH = 2**DATA_DEPTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             aempty_q, aempty_d;
  logic             afull_q, afull_d;
  logic             wr_acc, rd_acc;

  // Accept decisions look only at the registered flags.
  assign wr_acc = wr_req & ~full_q;
  assign rd_acc = rd_req & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
    empty_d  = (cnt_d == '0);
    full_d   = (cnt_d == CNT_W'(DEPTH));
    afull_d  = (cnt_d >= CNT_W'(AFULL_THRESH));
    aempty_d = (cnt_d <= CNT_W'(AEMPTY_THRESH));
  end

  always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
    end
  end

  // Storage is never reset; a flush only rewinds the pointers.
  always_ff @(posedge fifo_clk) begin
    if (wr_acc && !clr) mem[wr_ptr_q] <= wr_data;
  end

  assign use_num      = cnt_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = aempty_q;
  assign almost_full  = afull_q;

  generate
    if (SHOW_AHEAD != 0) begin : gen_fwft
      // Head word is presented combinationally; forced to zero while empty so reset/flush read back 0.
      assign rd_valid = ~empty_q;
      assign rd_data  = empty_q ? '0 : mem[rd_ptr_q];
    end else begin : gen_reg
      logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
      logic                  rd_valid_q, rd_valid_d;

      always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (clr) begin
          rd_data_d = '0;
        end else if (rd_acc) begin
          rd_data_d  = mem[rd_ptr_q];
          rd_valid_d = 1'b1;
        end
      end

      always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
        if (!fifo_rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky: only a flush or reset clears them.
  always_comb begin
    ovf_d = ovf_q | (wr_req & full_q);
    udf_d = udf_q | (rd_req & empty_q);
    if (clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a registered-read and a show-ahead instance share stimulus and are
// compared every cycle against a queue-based reference model.
module tb_sync_fifo;

  localparam int unsigned DW = 16;
  localparam int unsigned DD = 4;
  localparam int unsigned NENT = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr, wr_req, rd_req;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1;
  logic [DD:0]   use_num0, use_num1;
  logic          empty0, full0, aempty0, afull0, ovf0, udf0;
  logic          empty1, full1, aempty1, afull1, ovf1, udf1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd_data;
  logic          m_rd_valid;
  logic          m_ovf, m_udf;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .AFULL_THRESH(12), .AEMPTY_THRESH(4), .SHOW_AHEAD(0)) dut0 (
    .fifo_clk(clk), .fifo_rst_n(rst_n), .clr(clr), .wr_req(wr_req), .wr_data(wr_data), .rd_req(rd_req),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .use_num(use_num0), .empty(empty0), .full(full0),
    .almost_empty(aempty0), .almost_full(afull0), .overflow(ovf0), .underflow(udf0));

  sync_fifo #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .AFULL_THRESH(12), .AEMPTY_THRESH(4), .SHOW_AHEAD(1)) dut1 (
    .fifo_clk(clk), .fifo_rst_n(rst_n), .clr(clr), .wr_req(wr_req), .wr_data(wr_data), .rd_req(rd_req),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .use_num(use_num1), .empty(empty1), .full(full1),
    .almost_empty(aempty1), .almost_full(afull1), .overflow(ovf1), .underflow(udf1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
    m_ovf      = 1'b0;
    m_udf      = 1'b0;
  endtask

  // One clock edge of the FIFO's behaviour in terms of a plain queue.
  task automatic model_edge(input logic c, input logic w, input logic [DW-1:0] d, input logic r);
    int  n;
    logic was_full, was_empty;
    n = q.size();
    was_full  = (n == NENT);
    was_empty = (n == 0);
    if (c) begin
      model_reset();
    end else begin
      m_rd_valid = 1'b0;
      if (r && !was_empty) begin
        m_rd_data  = q.pop_front();
        m_rd_valid = 1'b1;
      end
      if (w && !was_full) q.push_back(d);
`ifdef SYNC_FIFO_ERR_EN
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_udf = 1'b1;
`endif
    end
  endtask

  task automatic check_all();
    int n;
    logic [DW-1:0] head;
    n = q.size();
    head = (n != 0) ? q[0] : '0;
    chk("use_num0", 32'(use_num0), 32'(n));
    chk("empty0", 32'(empty0), 32'(n == 0));
    chk("full0", 32'(full0), 32'(n == NENT));
    chk("almost_full0", 32'(afull0), 32'(n >= 12));
    chk("almost_empty0", 32'(aempty0), 32'(n <= 4));
    chk("rd_valid0", 32'(rd_valid0), 32'(m_rd_valid));
    chk("rd_data0", 32'(rd_data0), 32'(m_rd_data));
    chk("overflow0", 32'(ovf0), 32'(m_ovf));
    chk("underflow0", 32'(udf0), 32'(m_udf));
    chk("use_num1", 32'(use_num1), 32'(n));
    chk("full1", 32'(full1), 32'(n == NENT));
    chk("rd_valid1", 32'(rd_valid1), 32'(n != 0));
    chk("rd_data1", 32'(rd_data1), 32'(head));
    chk("overflow1", 32'(ovf1), 32'(m_ovf));
    chk("underflow1", 32'(udf1), 32'(m_udf));
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare 1 time unit later.
  task automatic cyc(input logic c, input logic w, input logic [DW-1:0] d, input logic r);
    clr = c; wr_req = w; wr_data = d; rd_req = r;
    @(posedge clk);
    #1;
    model_edge(c, w, d, r);
    check_all();
  endtask

  initial begin
    logic [DW-1:0] seq;
    rst_n = 1'b0; clr = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_data = '0;
    model_reset();
    #12;
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_all();

    // Fill with 1..16, then attempt a 17th write while full.
    for (int i = 1; i <= 16; i++) cyc(1'b0, 1'b1, DW'(i), 1'b0);
    cyc(1'b0, 1'b1, 16'hBEEF, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    // Read while full: write must be dropped, read accepted.
    cyc(1'b0, 1'b1, 16'hDEAD, 1'b1);
    cyc(1'b0, 1'b1, 16'h0011, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, '0, 1'b1);
    // Underflow, then read+write while empty.
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b1, 16'h0042, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b0);

    // Concurrent traffic at count 8.
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, DW'($urandom), 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b0);

    // Read latency of a single word.
    cyc(1'b0, 1'b1, 16'h1234, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);

    // Wrap-around with contiguous data 0..42.
    seq = '0;
    for (int i = 0; i < 3; i++) begin cyc(1'b0, 1'b1, seq, 1'b0); seq++; end
    for (int i = 0; i < 40; i++) begin cyc(1'b0, 1'b1, seq, 1'b1); seq++; end

    // Flush with concurrent requests at count 9.
    cyc(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, DW'($urandom), 1'b0);
    cyc(1'b0, 1'b1, '0, 1'b1);
    cyc(1'b1, 1'b1, 16'h5555, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0);

    // Random traffic: fill-biased, then drain-biased, with rare flushes.
    for (int i = 0; i < 400; i++) begin
      logic w, r, c;
      if (i < 200) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 2) == 0);
      end else begin
        w = ($urandom_range(0, 2) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      c = ($urandom_range(0, 63) == 0);
      cyc(c, w, DW'($urandom), r);
    end

    // Async reset mid-burst.
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, DW'($urandom), 1'b0);
    cyc(1'b0, 1'b1, DW'($urandom), 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    clr = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    @(posedge clk); #1;
    check_all();
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 16'hA5A5, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
